// File: rtl/ysyx_210544_lsu_cache_adapter.sv
// Load/store adapter between the MEM stage and the cache core.
// Latches one request, drives the hold-until-ack request to the core, then
// returns the width-extended load result with a one-cycle done pulse.
module ysyx_210544_lsu_cache_adapter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_lsu_valid,
  input  logic        i_lsu_op,
  input  logic [2:0]  i_lsu_funct3,
  input  logic [63:0] i_lsu_addr,
  input  logic [63:0] i_lsu_wdata,
  output logic        o_lsu_ready,
  output logic        o_lsu_busy,
  output logic        o_lsu_done,
  output logic [63:0] o_lsu_rdata,
  output logic [63:0] o_cache_core_addr,
  output logic [63:0] o_cache_core_wdata,
  output logic [2:0]  o_cache_core_bytes,
  output logic        o_cache_core_op,
  output logic        o_cache_core_req,
  input  logic [63:0] i_cache_core_rdata,
  input  logic        i_cache_core_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  funct3_p0;
  logic [2:0]  in_bytes;

  // Core byte-count encoding is (access bytes - 1): 0, 1, 3 or 7.
  function automatic logic [2:0] funct3_to_bytes(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd0;
      2'b01:   return 3'd1;
      2'b10:   return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  // Clear store data above the access width so the core never sees stale bits.
  function automatic logic [63:0] mask_store(input logic [63:0] d, input logic [2:0] nbytes);
    case (nbytes)
      3'd0:    return {56'd0, d[7:0]};
      3'd1:    return {48'd0, d[15:0]};
      3'd3:    return {32'd0, d[31:0]};
      default: return d;
    endcase
  endfunction

  // Sign- or zero-extend right-aligned load data; funct3[2] selects unsigned.
  function automatic logic [63:0] extend_load(input logic [63:0] d, input logic [2:0] f3);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;
    b_s = d[7:0];
    h_s = d[15:0];
    w_s = d[31:0];
    case (f3[1:0])
      2'b00:   return f3[2] ? {56'd0, d[7:0]}  : 64'(b_s);
      2'b01:   return f3[2] ? {48'd0, d[15:0]} : 64'(h_s);
      2'b10:   return f3[2] ? {32'd0, d[31:0]} : 64'(w_s);
      default: return d;
    endcase
  endfunction

  assign in_bytes    = funct3_to_bytes(i_lsu_funct3[1:0]);
  assign o_lsu_ready = (state == IDLE) & ~rst;
  assign o_lsu_busy  = (state != IDLE);

  // Request sequencing: accept in IDLE, hold req until ack, then wait for the
  // core to drop ack before accepting again so a stale ack cannot complete
  // the next operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      o_cache_core_req   <= 1'b0;
      o_lsu_done         <= 1'b0;
      o_lsu_rdata        <= 64'd0;
      o_cache_core_addr  <= 64'd0;
      o_cache_core_wdata <= 64'd0;
      o_cache_core_bytes <= 3'd0;
      o_cache_core_op    <= 1'b0;
      funct3_p0          <= 3'd0;
    end else begin
      o_lsu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_lsu_valid) begin
            o_cache_core_addr  <= i_lsu_addr;
            o_cache_core_wdata <= mask_store(i_lsu_wdata, in_bytes);
            o_cache_core_bytes <= in_bytes;
            o_cache_core_op    <= i_lsu_op;
            funct3_p0          <= i_lsu_funct3;
            o_cache_core_req   <= 1'b1;
            state              <= REQ;
          end
        end
        REQ: begin
          if (i_cache_core_ack) begin
            o_cache_core_req <= 1'b0;
            o_lsu_done       <= 1'b1;
            o_lsu_rdata      <= o_cache_core_op ? 64'd0
                                                : extend_load(i_cache_core_rdata, funct3_p0);
            state            <= RELEASE;
          end
        end
        RELEASE: begin
          if (!i_cache_core_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_210544_lsu_cache_adapter.sv
// Self-checking bench for the LSU/cache-core adapter with a behavioural
// cache-core responder and an arithmetic reference model.
module tb_ysyx_210544_lsu_cache_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_valid = 1'b0;
  logic        lsu_op = 1'b0;
  logic [2:0]  lsu_funct3 = 3'd0;
  logic [63:0] lsu_addr = 64'd0;
  logic [63:0] lsu_wdata = 64'd0;
  logic        o_lsu_ready, o_lsu_busy, o_lsu_done;
  logic [63:0] o_lsu_rdata, o_cache_core_addr, o_cache_core_wdata;
  logic [2:0]  o_cache_core_bytes;
  logic        o_cache_core_op, o_cache_core_req;
  logic        core_ack;

  int errors = 0;
  int checks = 0;

  // Responder configuration and state
  int          cfg_lat = 0;
  int          cfg_hold = 0;
  logic [63:0] cfg_rdata = 64'd0;
  logic        resp_ack = 1'b0;
  logic        spur_ack = 1'b0;
  int          r_cnt = 0;
  int          r_post = 0;

  assign core_ack = resp_ack | spur_ack;

  ysyx_210544_lsu_cache_adapter dut (
    .clk                (clk),
    .rst                (rst),
    .i_lsu_valid        (lsu_valid),
    .i_lsu_op           (lsu_op),
    .i_lsu_funct3       (lsu_funct3),
    .i_lsu_addr         (lsu_addr),
    .i_lsu_wdata        (lsu_wdata),
    .o_lsu_ready        (o_lsu_ready),
    .o_lsu_busy         (o_lsu_busy),
    .o_lsu_done         (o_lsu_done),
    .o_lsu_rdata        (o_lsu_rdata),
    .o_cache_core_addr  (o_cache_core_addr),
    .o_cache_core_wdata (o_cache_core_wdata),
    .o_cache_core_bytes (o_cache_core_bytes),
    .o_cache_core_op    (o_cache_core_op),
    .o_cache_core_req   (o_cache_core_req),
    .i_cache_core_rdata (cfg_rdata),
    .i_cache_core_ack   (core_ack)
  );

  always #5 clk = ~clk;

  // Cache core model: ack after cfg_lat cycles of req, hold while req is
  // high, then keep ack for cfg_hold extra cycles after req drops.
  always @(negedge clk) begin
    if (o_cache_core_req) begin
      r_post = cfg_hold;
      if (!resp_ack) begin
        if (r_cnt >= cfg_lat) resp_ack = 1'b1;
        else r_cnt++;
      end
    end else begin
      r_cnt = 0;
      if (resp_ack) begin
        if (r_post == 0) resp_ack = 1'b0;
        else r_post--;
      end
    end
  end

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  bytes;
    logic        op;
    int          cyc;
  } cap_t;
  typedef struct {
    logic [63:0] rdata;
    int          cyc;
  } done_t;

  cap_t  cap_q[$];
  done_t done_q[$];
  int    cyc = 0;
  int    stale_viol = 0;
  int    overlap_viol = 0;
  int    dbl_done = 0;
  logic  prev_req = 1'b0;
  logic  prev_done = 1'b0;

  // Bus monitor sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (o_cache_core_req && !prev_req) begin
      if (core_ack) stale_viol++;
      cap_q.push_back('{o_cache_core_addr, o_cache_core_wdata, o_cache_core_bytes,
                        o_cache_core_op, cyc});
    end
    if (o_lsu_done) begin
      done_q.push_back('{o_lsu_rdata, cyc});
      if (prev_done) dbl_done++;
      if (o_lsu_ready) overlap_viol++;
    end
    prev_req  = o_cache_core_req;
    prev_done = o_lsu_done;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  // Reference model
  function automatic int nbytes_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] d, input logic [2:0] f3);
    int nb = nbytes_of(f3);
    if (nb == 8) return d;
    return d & ((64'd1 << (nb * 8)) - 64'd1);
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] d, input logic [2:0] f3);
    int nb = nbytes_of(f3);
    logic [63:0] m, v;
    if (nb == 8) return d;
    m = (64'd1 << (nb * 8)) - 64'd1;
    v = d & m;
    if (!f3[2] && v[nb * 8 - 1]) v = v | ~m;
    return v;
  endfunction

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!o_lsu_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (o_lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got=%b want=1", o_lsu_ready);
    end
  endtask

  task automatic run_op(input string nm, input logic op, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] rd, input int lat, input int hold);
    int guard;
    logic [63:0] exp_rd;
    wait_ready();
    cap_q.delete();
    done_q.delete();
    cfg_lat = lat; cfg_hold = hold; cfg_rdata = rd;
    lsu_valid = 1'b1; lsu_op = op; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wdata;
    @(posedge clk); #1;
    checks++;
    if (o_cache_core_req !== 1'b1 || o_lsu_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_req_after_accept got=req%b/busy%b want=1/1", nm, o_cache_core_req, o_lsu_busy);
    end
    @(negedge clk);
    lsu_valid = 1'b0; lsu_op = $urandom; lsu_funct3 = $urandom;
    lsu_addr = {$urandom, $urandom}; lsu_wdata = {$urandom, $urandom};
    guard = 0;
    while (done_q.size() == 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    wait_ready();
    exp_rd = op ? 64'd0 : model_load(rd, f3);
    checks++;
    if (cap_q.size() != 1 || done_q.size() != 1) begin
      errors++;
      $display("FAIL %s_counts got=req%0d/done%0d want=1/1", nm, cap_q.size(), done_q.size());
    end
    if (cap_q.size() >= 1) begin
      checks++;
      if (cap_q[0].addr !== addr) begin
        errors++;
        $display("FAIL %s_addr got=%h want=%h", nm, cap_q[0].addr, addr);
      end
      checks++;
      if (cap_q[0].bytes !== 3'(nbytes_of(f3) - 1) || cap_q[0].op !== op) begin
        errors++;
        $display("FAIL %s_bytes_op got=%0d/%b want=%0d/%b", nm, cap_q[0].bytes, cap_q[0].op,
                 nbytes_of(f3) - 1, op);
      end
      checks++;
      if (cap_q[0].wdata !== model_wdata(wdata, f3)) begin
        errors++;
        $display("FAIL %s_wdata got=%h want=%h", nm, cap_q[0].wdata, model_wdata(wdata, f3));
      end
    end
    if (done_q.size() >= 1) begin
      checks++;
      if (done_q[0].rdata !== exp_rd) begin
        errors++;
        $display("FAIL %s_rdata got=%h want=%h", nm, done_q[0].rdata, exp_rd);
      end
      if (cap_q.size() >= 1) begin
        checks++;
        if (done_q[0].cyc !== cap_q[0].cyc + lat + 1) begin
          errors++;
          $display("FAIL %s_latency got=%0d want=%0d", nm, done_q[0].cyc - cap_q[0].cyc, lat + 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_cache_core_req !== 1'b0 || o_lsu_done !== 1'b0 || o_lsu_busy !== 1'b0 ||
        o_lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=req%b done%b busy%b ready%b want=0000",
               o_cache_core_req, o_lsu_done, o_lsu_busy, o_lsu_ready);
    end
    checks++;
    if (o_lsu_rdata !== 64'd0 || o_cache_core_addr !== 64'd0 || o_cache_core_wdata !== 64'd0 ||
        o_cache_core_bytes !== 3'd0 || o_cache_core_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got=%h/%h/%h/%0d/%b want=all zero", o_lsu_rdata,
               o_cache_core_addr, o_cache_core_wdata, o_cache_core_bytes, o_cache_core_op);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_lsu_ready !== 1'b1 || o_lsu_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got=ready%b busy%b want=1/0", o_lsu_ready, o_lsu_busy);
    end
  endtask

  task automatic test_directed();
    run_op("lb",  1'b0, 3'b000, 64'h0000_0000_8000_1003, 64'd0, 64'h0000_0000_0000_00F0, 2, 0);
    checks++;
    if (done_q.size() < 1 || done_q[0].rdata !== 64'hFFFF_FFFF_FFFF_FFF0) begin
      errors++;
      $display("FAIL lb_const_rdata got=%h want=fffffffffffffff0",
               done_q.size() ? done_q[0].rdata : 64'hx);
    end
    run_op("lhu", 1'b0, 3'b101, 64'h0000_0000_8000_100F, 64'd0, 64'h0000_0000_0000_8001, 1, 1);
    run_op("sw",  1'b1, 3'b010, 64'h0000_0000_8000_2000, 64'h1122_3344_5566_7788,
           64'hFFFF_0000_FFFF_0000, 3, 0);
    run_op("sb",  1'b1, 3'b000, 64'h0000_0000_8000_2007, 64'hAAAA_BBBB_CCCC_DDEE, 64'd0, 0, 0);
    run_op("ld",  1'b0, 3'b011, 64'h0000_0000_8000_3005, 64'd0, 64'h8123_4567_89AB_CDEF, 0, 2);
    run_op("lw",  1'b0, 3'b010, 64'h0000_0000_8000_3001, 64'd0, 64'h1234_5678_8000_0000, 1, 0);
    run_op("lwu", 1'b0, 3'b110, 64'h0000_0000_8000_3002, 64'd0, 64'h1234_5678_8000_0000, 1, 0);
    run_op("lh",  1'b0, 3'b001, 64'h0000_0000_8000_3003, 64'd0, 64'hFFFF_FFFF_FFFF_7FFF, 0, 0);
  endtask

  task automatic test_back_to_back();
    int guard;
    wait_ready();
    cap_q.delete();
    done_q.delete();
    cfg_lat = 1; cfg_hold = 2; cfg_rdata = 64'hDEAD_BEEF_0123_4567;
    lsu_valid = 1'b1; lsu_op = 1'b0; lsu_funct3 = 3'b011; lsu_addr = 64'h8000_4000;
    lsu_wdata = 64'd0;
    @(posedge clk);
    @(negedge clk);
    lsu_funct3 = 3'b010; lsu_addr = 64'h8000_4010;
    guard = 0;
    while (done_q.size() == 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    cfg_rdata = 64'h0000_0000_8000_0000;
    guard = 0;
    while (cap_q.size() < 2 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    lsu_valid = 1'b0;
    guard = 0;
    while (done_q.size() < 2 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    wait_ready();
    checks++;
    if (cap_q.size() != 2 || done_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_counts got=req%0d/done%0d want=2/2", cap_q.size(), done_q.size());
    end else begin
      checks++;
      if (cap_q[0].addr !== 64'h8000_4000 || cap_q[1].addr !== 64'h8000_4010 ||
          cap_q[0].bytes !== 3'd7 || cap_q[1].bytes !== 3'd3) begin
        errors++;
        $display("FAIL b2b_req got=%h/%0d,%h/%0d want=80004000/7,80004010/3",
                 cap_q[0].addr, cap_q[0].bytes, cap_q[1].addr, cap_q[1].bytes);
      end
      checks++;
      if (done_q[0].rdata !== 64'hDEAD_BEEF_0123_4567 ||
          done_q[1].rdata !== 64'hFFFF_FFFF_8000_0000) begin
        errors++;
        $display("FAIL b2b_rdata got=%h,%h want=deadbeef01234567,ffffffff80000000",
                 done_q[0].rdata, done_q[1].rdata);
      end
      checks++;
      if (cap_q[1].cyc < done_q[0].cyc + 4) begin
        errors++;
        $display("FAIL b2b_gap got=%0d want>=4", cap_q[1].cyc - done_q[0].cyc);
      end
    end
    checks++;
    if (stale_viol !== 0) begin
      errors++;
      $display("FAIL b2b_stale_ack got=%0d want=0", stale_viol);
    end
  endtask

  task automatic test_valid_while_busy();
    int guard;
    wait_ready();
    cap_q.delete();
    done_q.delete();
    cfg_lat = 6; cfg_hold = 0; cfg_rdata = 64'h0000_0000_0000_0080;
    lsu_valid = 1'b1; lsu_op = 1'b0; lsu_funct3 = 3'b000; lsu_addr = 64'h8000_5001;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lsu_valid = i[0] ? 1'b0 : 1'b1;
      lsu_addr  = 64'h9999_0000 + 64'(i);
      lsu_op    = 1'b1;
    end
    @(negedge clk);
    lsu_valid = 1'b0;
    checks++;
    if (o_cache_core_addr !== 64'h8000_5001 || o_cache_core_op !== 1'b0) begin
      errors++;
      $display("FAIL busy_latched got=%h/%b want=80005001/0", o_cache_core_addr, o_cache_core_op);
    end
    guard = 0;
    while (done_q.size() == 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    wait_ready();
    checks++;
    if (cap_q.size() != 1 || done_q.size() != 1) begin
      errors++;
      $display("FAIL busy_counts got=req%0d/done%0d want=1/1", cap_q.size(), done_q.size());
    end else begin
      checks++;
      if (done_q[0].rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin
        errors++;
        $display("FAIL busy_rdata got=%h want=ffffffffffffff80", done_q[0].rdata);
      end
    end
    done_q.delete();
    spur_ack = 1'b1;
    repeat (3) @(negedge clk);
    spur_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (done_q.size() != 0 || o_lsu_busy !== 1'b0 || o_cache_core_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_spurious_ack got=done%0d busy%b req%b want=0/0/0",
               done_q.size(), o_lsu_busy, o_cache_core_req);
    end
  endtask

  task automatic test_reset_mid_op();
    wait_ready();
    done_q.delete();
    cfg_lat = 20; cfg_hold = 0; cfg_rdata = 64'd5;
    lsu_valid = 1'b1; lsu_op = 1'b1; lsu_funct3 = 3'b011; lsu_addr = 64'h8000_6000;
    lsu_wdata = 64'h55;
    @(posedge clk);
    @(negedge clk);
    lsu_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o_cache_core_req !== 1'b0 || o_lsu_busy !== 1'b0 || o_lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_op got=req%b busy%b ready%b want=0/0/0",
               o_cache_core_req, o_lsu_busy, o_lsu_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (o_lsu_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready got=%b want=1", o_lsu_ready);
    end
    repeat (25) @(negedge clk);
    checks++;
    if (done_q.size() != 0 || o_lsu_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_done got=done%0d busy%b want=0/0", done_q.size(), o_lsu_busy);
    end
  endtask

  task automatic test_random();
    logic [2:0] f3;
    logic       op;
    for (int n = 0; n < 24; n++) begin
      op = 1'($urandom_range(0, 1));
      f3 = op ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      run_op("rand", op, f3, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (stale_viol !== 0 || overlap_viol !== 0 || dbl_done !== 0) begin
      errors++;
      $display("FAIL invariants got=stale%0d overlap%0d long_done%0d want=0/0/0",
               stale_viol, overlap_viol, dbl_done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_valid_while_busy();
    test_reset_mid_op();
    test_random();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
